// File: rtl/svi_sdram_pkg.sv
// rtl/svi_sdram_pkg.sv - shared types and address map for the SDRAM port arbiter
package svi_sdram_pkg;

  localparam int SD_AW  = 23;
  localparam int DL_AW  = 23;
  localparam int CLR_AW = 16;
  localparam int CPU_AW = 18;
  localparam int CAS_AW = 21;

  localparam logic [SD_AW-1:0] CLR_BASE = 23'h010000;
  localparam logic [SD_AW-1:0] CAS_BASE = 23'h600000;

  typedef enum logic [1:0] {
    GNT_DL  = 2'd0,
    GNT_CLR = 2'd1,
    GNT_CPU = 2'd2,
    GNT_CAS = 2'd3
  } grant_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/svi_arb_prio.sv
// rtl/svi_arb_prio.sv - combinational fixed-priority pick with cassette promotion
module svi_arb_prio
  import svi_sdram_pkg::*;
(
  input  logic   dl_req,
  input  logic   clr_req,
  input  logic   cpu_req,
  input  logic   cas_req,
  input  logic   cas_promoted,
  input  logic   cas_window,
  output grant_t grant,
  output logic   valid
);

  always_comb begin
    grant = GNT_DL;
    valid = 1'b1;
    if (dl_req)                          grant = GNT_DL;
    else if (clr_req)                    grant = GNT_CLR;
    else if (cas_req && cas_promoted)    grant = GNT_CAS;
    else if (cpu_req)                    grant = GNT_CPU;
    else if (cas_req && cas_window)      grant = GNT_CAS;
    else                                 valid = 1'b0;
  end

endmodule

// File: rtl/svi_sdram_arbiter.sv
// rtl/svi_sdram_arbiter.sv - four-way SDRAM port arbiter (ioctl, clear, CPU, cassette)
// Optional statistics block enabled by SVI_SDRAM_ARB_STATS_EN.
module svi_sdram_arbiter
  import svi_sdram_pkg::*;
#(
  parameter int CAS_MAX_WAIT = 64,
  parameter int TIMEOUT      = 32
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              dl_wr_i,
  input  logic [DL_AW-1:0]  dl_addr_i,
  input  logic [7:0]        dl_data_i,
  input  logic              clr_req_i,
  input  logic [CLR_AW-1:0] clr_addr_i,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [CPU_AW-1:0] cpu_addr_i,
  input  logic [7:0]        cpu_data_i,
  input  logic              cas_rd_i,
  input  logic [CAS_AW-1:0] cas_addr_i,
  input  logic              cas_window_i,
  output logic              dl_ack_o,
  output logic              clr_ack_o,
  output logic              cpu_ack_o,
  output logic              cas_ack_o,
  output logic [7:0]        rd_data_o,
  output logic              rd_valid_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [1:0]        grant_o,
  output logic [SD_AW-1:0]  sd_addr_o,
  output logic [7:0]        sd_din_o,
  output logic              sd_rd_o,
  output logic              sd_we_o,
  input  logic              sd_ready_i,
  input  logic [7:0]        sd_dout_i
`ifdef SVI_SDRAM_ARB_STATS_EN
  ,
  input  logic [2:0]        stat_sel_i,
  output logic [15:0]       stat_o
`endif
);

  localparam int CW = $clog2(CAS_MAX_WAIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CAS_LIM  = CW'(CAS_MAX_WAIT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  grant_t           grant_q, pick;
  logic             pick_valid, take, finish, tmo;
  logic             rd_q, pick_rd;
  logic [SD_AW-1:0] addr_q, pick_addr;
  logic [7:0]       din_q, pick_din;
  logic [TW-1:0]    tcnt;
  logic [CW-1:0]    cas_wait;
  logic [3:0]       ack_q;
  logic             cas_owns;

  svi_arb_prio u_prio (
    .dl_req       (dl_wr_i),
    .clr_req      (clr_req_i),
    .cpu_req      (cpu_rd_i | cpu_wr_i),
    .cas_req      (cas_rd_i),
    .cas_promoted (cas_wait >= CAS_LIM),
    .cas_window   (cas_window_i),
    .grant        (pick),
    .valid        (pick_valid)
  );

  always_comb begin
    pick_addr = dl_addr_i;
    pick_din  = dl_data_i;
    pick_rd   = 1'b0;
    case (pick)
      GNT_CLR: begin pick_addr = CLR_BASE | SD_AW'(clr_addr_i); pick_din = 8'h00; end
      GNT_CPU: begin pick_addr = SD_AW'(cpu_addr_i); pick_din = cpu_data_i; pick_rd = ~cpu_wr_i; end
      GNT_CAS: begin pick_addr = CAS_BASE | SD_AW'(cas_addr_i); pick_din = 8'h00; pick_rd = 1'b1; end
      default: ;
    endcase
  end

  // The ack cycle is excluded from granting so a requester still holding its
  // level for that one cycle is not served twice.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    finish  = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: if (sd_ready_i && pick_valid && ack_q == 4'b0000) begin
        take    = 1'b1;
        state_d = CMD;
      end
      CMD:  state_d = WAIT;
      WAIT: if (tcnt != '0 && sd_ready_i) begin
        finish  = 1'b1;
        state_d = IDLE;
      end else if (tcnt == TMO_LAST) begin
        tmo     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  assign cas_owns = (state_q != IDLE && grant_q == GNT_CAS) || ack_q[3];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      grant_q    <= GNT_DL;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      tcnt       <= '0;
      cas_wait   <= '0;
      ack_q      <= '0;
      rd_valid_o <= 1'b0;
      err_o      <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      ack_q      <= '0;
      rd_valid_o <= 1'b0;
      err_o      <= tmo;
      if (take) begin
        grant_q <= pick;
        rd_q    <= pick_rd;
        addr_q  <= pick_addr;
        din_q   <= pick_din;
      end
      if (state_q == CMD)       tcnt <= '0;
      else if (state_q == WAIT) tcnt <= tcnt + 1'b1;
      if (finish || tmo) ack_q <= 4'b0001 << grant_q;
      if (finish && rd_q) begin
        rd_data_o  <= sd_dout_i;
        rd_valid_o <= 1'b1;
      end
      if (take && pick == GNT_CAS)                  cas_wait <= '0;
      else if (cas_rd_i && !cas_owns && cas_wait != '1) cas_wait <= cas_wait + 1'b1;
    end
  end

  assign dl_ack_o  = ack_q[0];
  assign clr_ack_o = ack_q[1];
  assign cpu_ack_o = ack_q[2];
  assign cas_ack_o = ack_q[3];
  assign busy_o    = (state_q != IDLE);
  assign grant_o   = grant_q;
  assign sd_addr_o = addr_q;
  assign sd_din_o  = din_q;
  assign sd_rd_o   = (state_q == CMD) &&  rd_q;
  assign sd_we_o   = (state_q == CMD) && !rd_q;

`ifdef SVI_SDRAM_ARB_STATS_EN
  logic [15:0] gnt_cnt [4];
  logic [15:0] cas_cur, cas_max;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 4; i++) gnt_cnt[i] <= '0;
      cas_cur <= '0;
      cas_max <= '0;
    end else begin
      if (take && gnt_cnt[pick] != 16'hFFFF) gnt_cnt[pick] <= gnt_cnt[pick] + 16'd1;
      if (take && pick == GNT_CAS) begin
        if (cas_cur > cas_max) cas_max <= cas_cur;
        cas_cur <= '0;
      end else if (cas_rd_i && !cas_owns && cas_cur != 16'hFFFF) begin
        cas_cur <= cas_cur + 16'd1;
      end
    end
  end

  always_comb begin
    stat_o = '0;
    case (stat_sel_i)
      3'd0, 3'd1, 3'd2, 3'd3: stat_o = gnt_cnt[stat_sel_i[1:0]];
      3'd4:                   stat_o = cas_max;
      default:                stat_o = '0;
    endcase
  end
`endif

endmodule
